// File: rtl/nibble_serial_adder_ctrl_if.sv
// Bundle of request, result and adder-facing signals for the nibble-serial adder controller.
// No storage: pure wiring, zero latency.
// There is no backpressure. A request is taken only while the controller is idle, and busy reports when it is not.
interface nibble_serial_adder_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  // request side
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;

  // result side
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;

  // external 4-bit adder stage
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_sum;
  logic         add_cout;

  // requester / result consumer
  modport master (
    output start, a, b, carry_in,
    input  busy, done, sum, carry_out
  );

  // controller
  modport slave (
    input  start, a, b, carry_in, add_sum, add_cout,
    output busy, done, sum, carry_out, add_a, add_b, add_cin
  );

  // the 4-bit adder stage
  modport adder (
    input  add_a, add_b, add_cin,
    output add_sum, add_cout
  );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Builds a 4*NIBBLES-bit add by feeding a combinational 4-bit adder one nibble per cycle.
// Latency: start to done takes NIBBLES+1 cycles, and done is a one-cycle pulse.
// Backpressure: none. start is sampled only in IDLE, and busy covers RUN and DONE.

// 4-bit ripple-carry stage, written as dataflow full adders.
module ripple_adder_4bit_dataflow (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       carry_in,
  output logic [3:0] sum,
  output logic       carry_out
);
  logic c1, c2, c3;

  assign sum[0]    = a[0] ^ b[0] ^ carry_in;
  assign c1        = (a[0] & b[0]) | (a[0] & carry_in) | (b[0] & carry_in);
  assign sum[1]    = a[1] ^ b[1] ^ c1;
  assign c2        = (a[1] & b[1]) | (a[1] & c1) | (b[1] & c1);
  assign sum[2]    = a[2] ^ b[2] ^ c2;
  assign c3        = (a[2] & b[2]) | (a[2] & c2) | (b[2] & c2);
  assign sum[3]    = a[3] ^ b[3] ^ c3;
  assign carry_out = (a[3] & b[3]) | (a[3] & c3) | (b[3] & c3);
endmodule

module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  nibble_serial_adder_ctrl_if.slave  bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] idx_d;
  logic          carry_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  sum_q;
  logic          cout_q;
  logic          busy_q;
  logic          done_q;

  logic          last_nib;
  logic [3:0]    a_nib;
  logic [3:0]    b_nib;

  // Select the current nibble of each latched operand, and find the last slice.
  always_comb begin
    a_nib    = a_q[{idx_q, 2'b00} +: 4];
    b_nib    = b_q[{idx_q, 2'b00} +: 4];
    last_nib = (idx_q == IW'(NIBBLES - 1));
    idx_d    = idx_q + IW'(1);
  end

  // Keep the adder inputs quiet outside RUN, so idle cycles show no stray activity.
  assign bus.add_a   = (state_q == S_RUN) ? a_nib : 4'h0;
  assign bus.add_b   = (state_q == S_RUN) ? b_nib : 4'h0;
  assign bus.add_cin = (state_q == S_RUN) ? carry_q : 1'b0;

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;

  // Control FSM. It accepts a request, steps through the nibbles, then pulses done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.carry_in;
            idx_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          sum_q[{idx_q, 2'b00} +: 4] <= bus.add_sum;
          carry_q                    <= bus.add_cout;
          if (last_nib) begin
            // idx returns to 0 so it never points past the top slice.
            cout_q  <= bus.add_cout;
            done_q  <= 1'b1;
            idx_q   <= '0;
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_d;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          idx_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl, driving a real 4-bit ripple stage.
// Inputs are driven, and outputs sampled, on the falling clock edge.
// Expected sums are queued when a request is issued and popped on each done.
module tb_nibble_serial_adder_ctrl;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  nibble_serial_adder_ctrl_if #(.NIBBLES(N)) bus ();

  ripple_adder_4bit_dataflow u_add (
    .a(bus.add_a), .b(bus.add_b), .carry_in(bus.add_cin),
    .sum(bus.add_sum), .carry_out(bus.add_cout)
  );

  nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic [W:0] exp_q[$];

  always @(posedge clk) if (bus.done === 1'b1) done_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    bus.a        = a;
    bus.b        = b;
    bus.carry_in = cin;
    bus.start    = 1'b1;
    exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
  endtask

  // Wait for done. Each step is one falling edge, and the wait is bounded.
  task automatic wait_done(input int from, output int cycles, output bit hit);
    cycles = from;
    while (bus.done !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    hit = (bus.done === 1'b1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        output int lat, output bit hit);
    @(negedge clk);
    start_op(a, b, cin);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(1, lat, hit);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.carry_out} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b required 000", {bus.busy, bus.done, bus.carry_out});
    end
    n_checks++;
    if (bus.sum !== '0) begin
      n_fail++; $display("FAIL reset_sum: got %h required 0000", bus.sum);
    end
    n_checks++;
    if ({bus.add_a, bus.add_b, bus.add_cin} !== 9'd0) begin
      n_fail++; $display("FAIL reset_adder_drive: got %h required 000", {bus.add_a, bus.add_b, bus.add_cin});
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_busy: got %b required 0", bus.busy);
    end
  endtask

  task automatic test_basic();
    int lat; bit hit; logic [W:0] exp;
    @(negedge clk);
    start_op(16'h1234, 16'h4321, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    n_checks++;
    if ({bus.busy, bus.add_a, bus.add_b, bus.add_cin} !== {1'b1, 4'h4, 4'h1, 1'b0}) begin
      n_fail++; $display("FAIL first_nibble: got %h required %h",
                         {bus.busy, bus.add_a, bus.add_b, bus.add_cin}, {1'b1, 4'h4, 4'h1, 1'b0});
    end
    wait_done(1, lat, hit);
    n_checks++;
    if (!hit || lat != 5) begin
      n_fail++; $display("FAIL basic_latency: got %0d (hit=%0d) required 5", lat, hit);
    end
    exp = exp_q.pop_front();
    n_checks++;
    if ({bus.carry_out, bus.sum} !== exp) begin
      n_fail++; $display("FAIL basic_sum: got %h required %h", {bus.carry_out, bus.sum}, exp);
    end
    @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.carry_out, bus.sum, bus.add_a} !== {3'b000, 16'h5555, 4'h0}) begin
      n_fail++; $display("FAIL basic_hold: got %h required %h",
                         {bus.busy, bus.done, bus.carry_out, bus.sum, bus.add_a}, {3'b000, 16'h5555, 4'h0});
    end
  endtask

  task automatic test_carry();
    int lat; bit hit; logic [W:0] exp;
    run_op(16'hFFFF, 16'h0001, 1'b0, lat, hit);
    exp = exp_q.pop_front();
    n_checks++;
    if (!hit || {bus.carry_out, bus.sum} !== exp || exp !== 17'h10000) begin
      n_fail++; $display("FAIL carry_b1: got %h required %h", {bus.carry_out, bus.sum}, exp);
    end
    run_op(16'hFFFF, 16'h0000, 1'b1, lat, hit);
    exp = exp_q.pop_front();
    n_checks++;
    if (!hit || {bus.carry_out, bus.sum} !== exp) begin
      n_fail++; $display("FAIL carry_cin: got %h required %h", {bus.carry_out, bus.sum}, exp);
    end
  endtask

  task automatic test_ignore_start();
    int lat; bit hit; int d0; logic [W:0] exp;
    @(negedge clk);
    d0 = done_cnt;
    start_op(16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.carry_in = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(3, lat, hit);
    exp = exp_q.pop_front();
    n_checks++;
    if (!hit || {bus.carry_out, bus.sum} !== exp) begin
      n_fail++; $display("FAIL ignore_sum: got %h required %h", {bus.carry_out, bus.sum}, exp);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_cnt - d0 != 1 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL ignore_done_count: got %0d busy=%b required 1 busy=0", done_cnt - d0, bus.busy);
    end
  endtask

  task automatic test_reset_abort();
    int lat; bit hit; int d0; logic [W:0] exp;
    @(negedge clk);
    d0 = done_cnt;
    start_op(16'h1234, 16'h1111, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp = exp_q.pop_back();
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.carry_out, bus.sum, bus.add_a, bus.add_b, bus.add_cin} !== '0) begin
      n_fail++; $display("FAIL abort_outputs: got %h required 0",
                         {bus.busy, bus.done, bus.carry_out, bus.sum, bus.add_a, bus.add_b, bus.add_cin});
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    n_checks++;
    if (done_cnt != d0) begin
      n_fail++; $display("FAIL abort_no_done: got %0d done pulses required 0", done_cnt - d0);
    end
    run_op(16'h0ABC, 16'h0F0F, 1'b1, lat, hit);
    exp = exp_q.pop_front();
    n_checks++;
    if (!hit || {bus.carry_out, bus.sum} !== exp) begin
      n_fail++; $display("FAIL abort_restart: got %h required %h", {bus.carry_out, bus.sum}, exp);
    end
  endtask

  task automatic test_sweep();
    int lat; bit hit; logic [W:0] exp; logic [3:0] ni, nj;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        ni = i[3:0];
        nj = j[3:0];
        run_op({4{ni}}, {4{nj}}, ni[0], lat, hit);
        exp = exp_q.pop_front();
        n_checks++;
        if (!hit || lat != 5 || {bus.carry_out, bus.sum} !== exp) begin
          n_fail++; $display("FAIL sweep_%0d_%0d: got %h lat %0d required %h lat 5",
                             i, j, {bus.carry_out, bus.sum}, lat, exp);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int done_t[$]; int busy_low; logic prev_busy; logic [W:0] exp;
    @(negedge clk);
    @(negedge clk);
    prev_busy = bus.busy;
    busy_low  = 0;
    bus.a = 16'hABCD; bus.b = 16'h1357; bus.carry_in = 1'b1; bus.start = 1'b1;
    for (int t = 1; t <= 26; t++) begin
      @(negedge clk);
      if (bus.busy === 1'b1 && prev_busy !== 1'b1)
        exp_q.push_back({1'b0, bus.a} + {1'b0, bus.b} + {{W{1'b0}}, bus.carry_in});
      if (t <= 23 && bus.busy !== 1'b1) busy_low++;
      if (bus.done === 1'b1) begin
        done_t.push_back(t);
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_sum_t%0d: got done with no request required none", t);
        end else begin
          exp = exp_q.pop_front();
          if ({bus.carry_out, bus.sum} !== exp) begin
            n_fail++; $display("FAIL b2b_sum_t%0d: got %h required %h", t, {bus.carry_out, bus.sum}, exp);
          end
        end
      end
      prev_busy = bus.busy;
      if (t == 19) bus.start = 1'b0;
    end
    n_checks++;
    if (done_t.size() != 4) begin
      n_fail++; $display("FAIL b2b_count: got %0d required 4", done_t.size());
    end else begin
      n_checks++;
      if (done_t[0] != 5) begin
        n_fail++; $display("FAIL b2b_first: got %0d required 5", done_t[0]);
      end
      for (int k = 1; k < 4; k++) begin
        n_checks++;
        if (done_t[k] - done_t[k-1] != 6) begin
          n_fail++; $display("FAIL b2b_spacing_%0d: got %0d required 6", k, done_t[k] - done_t[k-1]);
        end
      end
    end
    n_checks++;
    if (busy_low != 3) begin
      n_fail++; $display("FAIL b2b_busy_gap: got %0d low cycles required 3", busy_low);
    end
    exp_q.delete();
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.carry_in = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_ignore_start();
    test_reset_abort();
    test_sweep();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
